montmul_pipe: RTL

- Parametrised, fully pipelined Montgomery modular multiplier for the NTT butterfly datapath.
- Accepts one operand pair per cycle under a valid/ready handshake.
- Produces either the Montgomery product A*B*R^-1 mod q or the plain product A*B mod q, selected per transaction. R = 2^K.
- Modulus constants are runtime ports, so one instance serves any NTT-friendly prime q < 2^W.

---
 rtl/montmul_pipe.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/montmul_pipe.sv
// montmul_pipe: six-stage Montgomery multiplier with R = 2^K and runtime modulus.
// Define MONTMUL_TAG_EN to carry a per-transaction tag (TAG_W bits) with each result.
module montmul_pipe #(
    parameter int W = 12,
    parameter int K = 16
`ifdef MONTMUL_TAG_EN
    ,
    parameter int TAG_W = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     q,
    input  logic [K-1:0]     q_ninv,
    input  logic [W-1:0]     r2,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
`ifdef MONTMUL_TAG_EN
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_c
);

    localparam int TW = 2 * W;
    localparam int SW = ((TW > K + W) ? TW : K + W) + 1;
    localparam int MW = (TW > K) ? TW : K;
    localparam int UW = W + 1;

    // m = ((t mod R) * ninv) mod R; the product's low K bits are all that matter
    function automatic logic [K-1:0] mfac(
        input logic [TW-1:0] t,
        input logic [K-1:0]  ninv
    );
        return K'(MW'(t) * MW'(ninv));
    endfunction

    function automatic logic [W-1:0] redc(
        input logic [TW-1:0] t,
        input logic [K-1:0]  m,
        input logic [W-1:0]  qq
    );
        logic [SW-1:0] s;
        logic [UW-1:0] u;
        s = SW'(t) + SW'(m) * SW'(qq);
        u = UW'(s >> K);
        return (u >= UW'(qq)) ? W'(u - UW'(qq)) : W'(u);
    endfunction

    logic          adv;

    logic          s1_v_q, s1_v_d;
    logic          s1_mode_q, s1_mode_d;
    logic [TW-1:0] s1_t_q, s1_t_d;

    logic          s2_v_q, s2_v_d;
    logic          s2_mode_q, s2_mode_d;
    logic [TW-1:0] s2_t_q, s2_t_d;
    logic [K-1:0]  s2_m_q, s2_m_d;

    logic          s3_v_q, s3_v_d;
    logic          s3_mode_q, s3_mode_d;
    logic [W-1:0]  s3_u_q, s3_u_d;

    logic          s4_v_q, s4_v_d;
    logic          s4_mode_q, s4_mode_d;
    logic [TW-1:0] s4_t_q, s4_t_d;

    logic          s5_v_q, s5_v_d;
    logic          s5_mode_q, s5_mode_d;
    logic [TW-1:0] s5_t_q, s5_t_d;
    logic [K-1:0]  s5_m_q, s5_m_d;

    logic          out_v_q, out_v_d;
    logic [W-1:0]  out_c_q, out_c_d;

`ifdef MONTMUL_TAG_EN
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic [TAG_W-1:0] s3_tag_q, s3_tag_d;
    logic [TAG_W-1:0] s4_tag_q, s4_tag_d;
    logic [TAG_W-1:0] s5_tag_q, s5_tag_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
`endif

    assign adv       = !out_v_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_v_q;
    assign out_c     = out_c_q;
`ifdef MONTMUL_TAG_EN
    assign out_tag   = out_tag_q;
`endif

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_mode_d = s1_mode_q;
        s1_t_d    = s1_t_q;
        s2_v_d    = s2_v_q;
        s2_mode_d = s2_mode_q;
        s2_t_d    = s2_t_q;
        s2_m_d    = s2_m_q;
        s3_v_d    = s3_v_q;
        s3_mode_d = s3_mode_q;
        s3_u_d    = s3_u_q;
        s4_v_d    = s4_v_q;
        s4_mode_d = s4_mode_q;
        s4_t_d    = s4_t_q;
        s5_v_d    = s5_v_q;
        s5_mode_d = s5_mode_q;
        s5_t_d    = s5_t_q;
        s5_m_d    = s5_m_q;
        out_v_d   = out_v_q;
        out_c_d   = out_c_q;
`ifdef MONTMUL_TAG_EN
        s1_tag_d  = s1_tag_q;
        s2_tag_d  = s2_tag_q;
        s3_tag_d  = s3_tag_q;
        s4_tag_d  = s4_tag_q;
        s5_tag_d  = s5_tag_q;
        out_tag_d = out_tag_q;
`endif
        if (adv) begin
            s1_v_d    = in_valid;
            s1_mode_d = in_mode;
            s1_t_d    = TW'(in_a) * TW'(in_b);

            s2_v_d    = s1_v_q;
            s2_mode_d = s1_mode_q;
            s2_t_d    = s1_t_q;
            s2_m_d    = mfac(s1_t_q, q_ninv);

            s3_v_d    = s2_v_q;
            s3_mode_d = s2_mode_q;
            s3_u_d    = redc(s2_t_q, s2_m_q, q);

            // plain-product mode re-enters the Montgomery domain via R^2
            s4_v_d    = s3_v_q;
            s4_mode_d = s3_mode_q;
            s4_t_d    = s3_mode_q ? TW'(s3_u_q) * TW'(r2) : TW'(s3_u_q);

            s5_v_d    = s4_v_q;
            s5_mode_d = s4_mode_q;
            s5_t_d    = s4_t_q;
            s5_m_d    = s4_mode_q ? mfac(s4_t_q, q_ninv) : '0;

            out_v_d   = s5_v_q;
            if (s5_v_q) begin
                out_c_d = s5_mode_q ? redc(s5_t_q, s5_m_q, q) : W'(s5_t_q);
            end
`ifdef MONTMUL_TAG_EN
            s1_tag_d  = in_tag;
            s2_tag_d  = s1_tag_q;
            s3_tag_d  = s2_tag_q;
            s4_tag_d  = s3_tag_q;
            s5_tag_d  = s4_tag_q;
            if (s5_v_q) begin
                out_tag_d = s5_tag_q;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            s4_v_q    <= 1'b0;
            s5_v_q    <= 1'b0;
            out_v_q   <= 1'b0;
            out_c_q   <= '0;
`ifdef MONTMUL_TAG_EN
            s1_tag_q  <= '0;
            s2_tag_q  <= '0;
            s3_tag_q  <= '0;
            s4_tag_q  <= '0;
            s5_tag_q  <= '0;
            out_tag_q <= '0;
`endif
        end else begin
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            s3_v_q    <= s3_v_d;
            s4_v_q    <= s4_v_d;
            s5_v_q    <= s5_v_d;
            out_v_q   <= out_v_d;
            out_c_q   <= out_c_d;
`ifdef MONTMUL_TAG_EN
            s1_tag_q  <= s1_tag_d;
            s2_tag_q  <= s2_tag_d;
            s3_tag_q  <= s3_tag_d;
            s4_tag_q  <= s4_tag_d;
            s5_tag_q  <= s5_tag_d;
            out_tag_q <= out_tag_d;
`endif
        end
    end

    // datapath registers need no reset; the valid bits qualify them
    always_ff @(posedge clk) begin
        s1_mode_q <= s1_mode_d;
        s1_t_q    <= s1_t_d;
        s2_mode_q <= s2_mode_d;
        s2_t_q    <= s2_t_d;
        s2_m_q    <= s2_m_d;
        s3_mode_q <= s3_mode_d;
        s3_u_q    <= s3_u_d;
        s4_mode_q <= s4_mode_d;
        s4_t_q    <= s4_t_d;
        s5_mode_q <= s5_mode_d;
        s5_t_q    <= s5_t_d;
        s5_m_q    <= s5_m_d;
    end

endmodule
